// File: rtl/ram_arbiter.sv
// Cycle-stealing arbiter sharing the CPU 1K x 8 data RAM with one DMA requester.
// Define RAM_ARB_WRPROT_EN to block DMA writes into page 0x300-0x3FF.
module ram_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic          CPU_USE,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_DATA,
    output logic          CPU_HOLD,
    input  logic          DMA_REQ,
    input  logic [4:0]    DMA_LEN,
    input  logic          DMA_WE,
    input  logic [AW-1:0] DMA_ADDR,
    input  logic [DW-1:0] DMA_WDATA,
    output logic          DMA_GNT,
    output logic          DMA_ACK,
    output logic [DW-1:0] DMA_RDATA,
    output logic          DMA_DONE,
    output logic          DMA_ERR,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_DATA,
    output logic          RAM_WE,
    input  logic [DW-1:0] RAM_Q
);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    localparam logic [7:0] LP_MAX = 8'(MAX_WAIT);

    state_t     r_state, w_state_nx;
    logic [4:0] r_beat, w_beat_nx;
    logic [7:0] r_wait, w_wait_nx;
    logic       r_hold, w_hold_nx;
    logic       w_own;
    logic       w_prot;

    assign w_own = nRESET && (r_state == BURST) && DMA_REQ
                   && (!CPU_USE || r_hold);

`ifdef RAM_ARB_WRPROT_EN
    logic r_err;

    assign w_prot = DMA_WE && (DMA_ADDR[AW-1 -: 2] == 2'b11);

    always_ff @(posedge CLK) begin
        if (!nRESET)
            r_err <= 1'b0;
        else if (w_own && w_prot)
            r_err <= 1'b1;
    end

    assign DMA_ERR = r_err;
`else
    assign w_prot  = 1'b0;
    assign DMA_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_wait  <= '0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_beat  <= w_beat_nx;
            r_wait  <= w_wait_nx;
            r_hold  <= w_hold_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_beat_nx  = r_beat;
        w_wait_nx  = r_wait;
        w_hold_nx  = r_hold;
        unique case (r_state)
            IDLE: begin
                w_wait_nx = '0;
                w_hold_nx = 1'b0;
                if (DMA_REQ) begin
                    w_state_nx = BURST;
                    w_beat_nx  = (DMA_LEN == 5'd0) ? 5'd16 : DMA_LEN;
                end
            end
            BURST: begin
                if (!DMA_REQ) begin
                    w_state_nx = IDLE;
                    w_beat_nx  = '0;
                    w_wait_nx  = '0;
                    w_hold_nx  = 1'b0;
                end else if (w_own) begin
                    w_wait_nx = '0;
                    w_hold_nx = r_hold || (r_wait == LP_MAX);
                    if (r_beat == 5'd1) begin
                        w_state_nx = DONE;
                        w_beat_nx  = '0;
                        w_hold_nx  = 1'b0;
                    end else begin
                        w_beat_nx = r_beat - 5'd1;
                    end
                end else begin
                    // denied cycles only occur while hold is low
                    w_hold_nx = (r_wait == LP_MAX);
                    if (r_wait != LP_MAX)
                        w_wait_nx = r_wait + 8'd1;
                end
            end
            DONE: begin
                w_state_nx = IDLE;
                w_wait_nx  = '0;
                w_hold_nx  = 1'b0;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign DMA_GNT   = (r_state == BURST);
    assign DMA_DONE  = (r_state == DONE);
    assign CPU_HOLD  = r_hold;
    assign DMA_ACK   = w_own;
    assign DMA_RDATA = RAM_Q;
    assign RAM_ADDR  = w_own ? DMA_ADDR : CPU_ADDR;
    assign RAM_DATA  = w_own ? DMA_WDATA : CPU_DATA;
    assign RAM_WE    = nRESET && (w_own ? (DMA_WE && !w_prot) : CPU_WE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed bursts plus random CPU/DMA traffic.
// A behavioural RAM lives here; the reference memory tracks expected contents.
module tb_ram_arbiter;

    localparam int MW = 15;
`ifdef RAM_ARB_WRPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       CPU_USE, CPU_WE;
    logic [9:0] CPU_ADDR;
    logic [7:0] CPU_DATA;
    logic       CPU_HOLD;
    logic       DMA_REQ;
    logic [4:0] DMA_LEN;
    logic       DMA_WE;
    logic [9:0] DMA_ADDR;
    logic [7:0] DMA_WDATA;
    logic       DMA_GNT, DMA_ACK, DMA_DONE, DMA_ERR;
    logic [7:0] DMA_RDATA;
    logic [9:0] RAM_ADDR;
    logic [7:0] RAM_DATA;
    logic       RAM_WE;
    logic [7:0] RAM_Q;

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];
    bit         mem_init = 1'b0;
    bit         err_exp  = 1'b0;
    int         n_chk    = 0;
    int         n_fail   = 0;

    ram_arbiter #(.AW(10), .DW(8), .MAX_WAIT(MW)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .CPU_USE(CPU_USE), .CPU_WE(CPU_WE),
        .CPU_ADDR(CPU_ADDR), .CPU_DATA(CPU_DATA),
        .CPU_HOLD(CPU_HOLD),
        .DMA_REQ(DMA_REQ), .DMA_LEN(DMA_LEN), .DMA_WE(DMA_WE),
        .DMA_ADDR(DMA_ADDR), .DMA_WDATA(DMA_WDATA),
        .DMA_GNT(DMA_GNT), .DMA_ACK(DMA_ACK), .DMA_RDATA(DMA_RDATA),
        .DMA_DONE(DMA_DONE), .DMA_ERR(DMA_ERR),
        .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA), .RAM_WE(RAM_WE),
        .RAM_Q(RAM_Q)
    );

    always #5 CLK = ~CLK;

    assign RAM_Q = mem[RAM_ADDR];

    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 5);
            mem_init <= 1'b1;
        end else if (RAM_WE) begin
            mem[RAM_ADDR] <= RAM_DATA;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        chk(tag, 32'(bad), 0);
    endtask

    // mode: 0 CPU idle, 1 CPU busy 1,0,1,0.., 2 CPU always busy, 3 random
    task automatic burst(input int len, input bit we, input logic [9:0] base,
                         input logic [7:0] d0, input int mode,
                         input int abort_at);
        int         left, idx, streak, cyc;
        bit         hold, ack, prot, use_, cwe;
        logic [9:0] a, ca;
        logic [7:0] cd;
        left   = (len == 0) ? 16 : len;
        idx    = 0;
        streak = 0;
        cyc    = 0;
        hold   = 1'b0;
        DMA_REQ   = 1'b1;
        DMA_LEN   = 5'(len);
        DMA_WE    = we;
        DMA_ADDR  = base;
        DMA_WDATA = d0;
        CPU_USE   = 1'b0;
        CPU_WE    = 1'b0;
        @(negedge CLK);
        chk("idle_gnt", DMA_GNT, 0);
        chk("idle_ack", DMA_ACK, 0);
        tick;
        while (left > 0 && idx != abort_at) begin
            if (cyc > 300) begin
                chk("burst_timeout", 32'(cyc), 0);
                break;
            end
            a = base + 10'(idx);
            case (mode)
                0:       use_ = 1'b0;
                1:       use_ = (cyc % 2 == 0);
                2:       use_ = 1'b1;
                default: use_ = ($urandom_range(0, 2) != 0);
            endcase
            cwe = use_ && ($urandom_range(0, 1) == 1);
            ca  = 10'h200 | 10'($urandom_range(0, 255));
            cd  = 8'($urandom);
            CPU_USE   = use_;
            CPU_WE    = cwe;
            CPU_ADDR  = ca;
            CPU_DATA  = cd;
            DMA_ADDR  = a;
            DMA_WDATA = d0 + 8'(idx);
            ack  = !use_ || hold;
            prot = PROT && we && (a[9:8] == 2'b11);
            @(negedge CLK);
            chk("gnt", DMA_GNT, 1);
            chk("hold", CPU_HOLD, 32'(hold));
            chk("ack", DMA_ACK, 32'(ack));
            chk("ram_addr", RAM_ADDR, ack ? a : ca);
            chk("ram_we", RAM_WE, ack ? 32'(we && !prot) : 32'(cwe));
            if (ack && !we) chk("rdata", DMA_RDATA, ref_mem[a]);
            @(posedge CLK);
            if (streak == MW) hold = 1'b1;
            if (ack) begin
                streak = 0;
                if (we && !prot) ref_mem[a] = d0 + 8'(idx);
                if (prot) err_exp = 1'b1;
                idx++;
                left--;
            end else begin
                if (cwe) ref_mem[ca] = cd;
                if (streak < MW) streak++;
            end
            cyc++;
            #1;
        end
        DMA_REQ = 1'b0;
        CPU_USE = 1'b0;
        CPU_WE  = 1'b0;
        if (left > 0) begin
            @(negedge CLK);
            chk("abort_ack", DMA_ACK, 0);
            chk("abort_done0", DMA_DONE, 0);
            tick;
            @(negedge CLK);
            chk("abort_gnt", DMA_GNT, 0);
            chk("abort_hold", CPU_HOLD, 0);
            chk("abort_done1", DMA_DONE, 0);
        end else begin
            @(negedge CLK);
            chk("done_pulse", DMA_DONE, 1);
            chk("done_gnt", DMA_GNT, 0);
            chk("done_hold", CPU_HOLD, 0);
            chk("done_ack", DMA_ACK, 0);
            tick;
            @(negedge CLK);
            chk("done_clear", DMA_DONE, 0);
            chk("idle_gnt2", DMA_GNT, 0);
        end
        chk("err", DMA_ERR, 32'(err_exp));
        tick;
    endtask

    initial begin
        logic [7:0] old;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 5);
        nRESET    = 1'b0;
        DMA_REQ   = 1'b1;
        DMA_LEN   = 5'd4;
        DMA_WE    = 1'b1;
        DMA_ADDR  = 10'h010;
        DMA_WDATA = 8'h00;
        CPU_USE   = 1'b1;
        CPU_WE    = 1'b1;
        CPU_ADDR  = 10'h020;
        CPU_DATA  = 8'hEE;
        repeat (3) tick;
        @(negedge CLK);
        chk("rst_ram_we", RAM_WE, 0);
        chk("rst_ack", DMA_ACK, 0);
        chk("rst_gnt", DMA_GNT, 0);
        chk("rst_hold", CPU_HOLD, 0);
        chk("rst_done", DMA_DONE, 0);
        chk("rst_err", DMA_ERR, 0);
        DMA_REQ = 1'b0;
        CPU_USE = 1'b0;
        CPU_WE  = 1'b0;
        nRESET  = 1'b1;
        tick;
        chk_mem("rst_mem");

        burst(4, 1'b1, 10'h010, 8'hA0, 0, -1);
        chk("t1_mem0", mem[10'h010], 8'hA0);
        chk("t1_mem3", mem[10'h013], 8'hA3);
        chk_mem("t1_mem");

        burst(2, 1'b0, 10'h010, 8'h00, 1, -1);

        burst(0, 1'b1, 10'h100, 8'h40, 2, -1);
        chk_mem("starve_mem");

        burst(8, 1'b1, 10'h080, 8'h30, 0, 2);
        chk("abort_mem", mem[10'h082], ref_mem[10'h082]);
        chk_mem("abort_all");

        DMA_REQ  = 1'b1;
        DMA_LEN  = 5'd8;
        DMA_WE   = 1'b0;
        DMA_ADDR = 10'h050;
        CPU_USE  = 1'b1;
        CPU_WE   = 1'b0;
        repeat (MW + 2) tick;
        @(negedge CLK);
        chk("mid_hold", CPU_HOLD, 1);
        chk("mid_ack", DMA_ACK, 1);
        nRESET  = 1'b0;
        CPU_USE = 1'b0;
        CPU_WE  = 1'b1;
        DMA_WE  = 1'b1;
        #1;
        chk("mid_rst_ack", DMA_ACK, 0);
        chk("mid_rst_we", RAM_WE, 0);
        tick;
        chk("mid_rst_gnt", DMA_GNT, 0);
        chk("mid_rst_hold", CPU_HOLD, 0);
        chk("mid_rst_done", DMA_DONE, 0);
        DMA_REQ = 1'b0;
        CPU_WE  = 1'b0;
        DMA_WE  = 1'b0;
        nRESET  = 1'b1;
        err_exp = 1'b0;
        tick;
        chk_mem("mid_rst_mem");

        old = ref_mem[10'h3F0];
        burst(1, 1'b1, 10'h3F0, 8'h55, 0, -1);
        chk("prot_mem", mem[10'h3F0], PROT ? old : 8'h55);
        chk("prot_err", DMA_ERR, 32'(PROT));

        for (int r = 0; r < 6; r++) begin
            burst(int'($urandom_range(0, 16)), 1'($urandom_range(0, 1)),
                  10'($urandom), 8'($urandom), 3, -1);
        end
        chk_mem("rand_mem");
        chk("final_err", DMA_ERR, 32'(err_exp));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
